// File: rtl/handshake_fifo_break_dv.sv
// handshake_fifo_break_dv: circular-buffer FIFO whose valid/data outputs come only from registered state.
module handshake_fifo_break_dv #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);
  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);
  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic push, pop;
  assign ins_ready  = count != FULL;
  assign outs_valid = count != '0;
  assign outs       = mem[head];
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= pop ? (head == LAST ? '0 : head + 1'b1) : head;
      tail  <= push ? (tail == LAST ? '0 : tail + 1'b1) : tail;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // storage needs no reset: count alone decides which slots are live
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= ins;
  end
endmodule

// File: tb/tb_handshake_fifo_break_dv.sv
// tb_handshake_fifo_break_dv: directed checks of a 4-slot and a 3-slot instance.
module tb_handshake_fifo_break_dv;
  logic clk = 0;
  logic rst;
  logic [21:0] ins, outs, ins_b, outs_b;
  logic ins_valid, ins_ready, outs_valid, outs_ready;
  logic ins_valid_b, ins_ready_b, outs_valid_b, outs_ready_b;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  handshake_fifo_break_dv #(.DATA_WIDTH(22), .NUM_SLOTS(4)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready));

  handshake_fifo_break_dv #(.DATA_WIDTH(22), .NUM_SLOTS(3)) dut_b (
    .clk(clk), .rst(rst), .ins(ins_b), .ins_valid(ins_valid_b), .ins_ready(ins_ready_b),
    .outs(outs_b), .outs_valid(outs_valid_b), .outs_ready(outs_ready_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; ins = '0; ins_valid = 0; outs_ready = 0;
    ins_b = '0; ins_valid_b = 0; outs_ready_b = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", outs_valid, 0);
      chk("rst_ready", ins_ready, 1);
    end
    rst = 0;
    tick();
    chk("idle_valid", outs_valid, 0);
    chk("idle_ready", ins_ready, 1);

    ins = 22'h1C9A2D; ins_valid = 1; outs_ready = 1;
    tick();
    ins_valid = 0;
    chk("single_valid", outs_valid, 1);
    chk("single_data", outs, 22'h1C9A2D);
    tick();
    chk("single_gone", outs_valid, 0);

    outs_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      ins = 22'(i); ins_valid = 1;
      chk($sformatf("fill_ready%0d", i), ins_ready, (i <= 4) ? 1 : 0);
      tick();
    end
    chk("full_valid", outs_valid, 1);
    chk("full_head", outs, 1);
    tick();
    chk("hold_head", outs, 1);
    chk("hold_valid", outs_valid, 1);
    chk("hold_ready", ins_ready, 0);
    outs_ready = 1;
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("drain_valid%0d", j), outs_valid, 1);
      chk($sformatf("drain_data%0d", j), outs, j);
      if (j == 1) chk("drain_stall", ins_ready, 0);
      tick();
      if (j == 2) ins_valid = 0;
    end
    chk("drain_empty", outs_valid, 0);

    outs_ready = 0;
    for (int i = 0; i < 4; i++) begin
      ins = 22'(16 + i); ins_valid = 1;
      tick();
    end
    ins = 22'h14; outs_ready = 1;
    chk("fullpop_block", ins_ready, 0);
    tick();
    chk("fullpop_resume", ins_ready, 1);
    chk("fullpop_head", outs, 22'h11);
    outs_ready = 0;
    tick();
    ins_valid = 0;
    chk("fullpop_refull", ins_ready, 0);
    outs_ready = 1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("fullpop_data%0d", j), outs, 17 + j);
      tick();
    end
    chk("fullpop_empty", outs_valid, 0);

    outs_ready = 0;
    for (int i = 0; i < 3; i++) begin
      ins = 22'(33 + i); ins_valid = 1;
      tick();
    end
    chk("mid_buffered", outs_valid, 1);
    rst = 1; ins = 22'h3FFFFF; outs_ready = 1;
    tick();
    rst = 0; ins_valid = 0;
    chk("mid_rst_valid", outs_valid, 0);
    chk("mid_rst_ready", ins_ready, 1);
    chk("mid_rst_ready_b", ins_ready_b, 1);
    tick();
    chk("mid_no_stale", outs_valid, 0);
    ins = 22'h1C9A2D; ins_valid = 1;
    tick();
    ins_valid = 0;
    chk("mid_push_valid", outs_valid, 1);
    chk("mid_push_data", outs, 22'h1C9A2D);
    tick();
    chk("mid_push_alone", outs_valid, 0);

    outs_ready_b = 1;
    for (int c = 0; c <= 20; c++) begin
      ins_valid_b = c < 20;
      ins_b = 22'(c + 1);
      if (c < 20) chk($sformatf("stream_ready%0d", c), ins_ready_b, 1);
      chk($sformatf("stream_valid%0d", c), outs_valid_b, (c > 0) ? 1 : 0);
      if (c > 0) chk($sformatf("stream_data%0d", c), outs_b, c);
      tick();
    end
    ins_valid_b = 0;
    chk("stream_end", outs_valid_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
